// File: rtl/sumu2_pkg.sv
// rtl/sumu2_pkg.sv - shared constants and types for the seven-input voter
package sumu2_pkg;
   localparam int N_VOTERS = 7;
   localparam int COUNT_W  = 3;

   typedef logic [N_VOTERS-1:0] ballot_t;
   typedef logic [COUNT_W-1:0]  count_t;
endpackage

// File: rtl/sumu2_popcount7.sv
// rtl/sumu2_popcount7.sv - combinational population count of a seven-bit ballot vector
module popcount7
   import sumu2_pkg::*;
(
   input  ballot_t ballot_i,
   output count_t  count_o
);

   // Seven single-bit terms never exceed 7, so the 3-bit sum cannot wrap.
   always_comb begin
      count_o = '0;
      for (int i = 0; i < N_VOTERS; i++) begin
         count_o = count_o + count_t'(ballot_i[i]);
      end
   end

endmodule

// File: rtl/sumu2_voter.sv
// rtl/sumu2_voter.sv - registered seven-input majority voter with tally output
module sumu2_voter
   import sumu2_pkg::*;
#(
   parameter int THRESHOLD = 4
)
(
   input  logic               clk,
   input  logic               rst,
   input  logic               A1,
   input  logic               A2,
   input  logic               A3,
   input  logic               A4,
   input  logic               A5,
   input  logic               A6,
   input  logic               A7,
   output logic               OUT,
   output logic [COUNT_W-1:0] COUNT
);

   if (THRESHOLD < 1 || THRESHOLD > N_VOTERS) begin : g_bad_threshold
      $error("sumu2_voter: THRESHOLD must be within 1..7");
   end

   localparam count_t THR = count_t'(THRESHOLD);

   ballot_t ballot;
   count_t  pop;
   count_t  count_q, count_d;
   logic    out_q, out_d;

   assign ballot = {A7, A6, A5, A4, A3, A2, A1};

   popcount7 u_popcount7 (
      .ballot_i (ballot),
      .count_o  (pop)
   );

   always_comb begin
      count_d = pop;
      out_d   = (pop >= THR);
   end

   // Both outputs share one register stage so they can never disagree.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
         out_q   <= 1'b0;
      end else begin
         count_q <= count_d;
         out_q   <= out_d;
      end
   end

   assign COUNT = count_q;
   assign OUT   = out_q;

endmodule

// File: tb/tb_sumu2_voter.sv
// tb/tb_sumu2_voter.sv - self-checking bench for sumu2_voter at THRESHOLD 4 and 7
module tb_sumu2_voter;

   logic       clk = 1'b0;
   logic       rst;
   logic [6:0] ballots;
   logic       out4, out7;
   logic [2:0] count4, count7;

   int checks = 0;
   int passed = 0;

   int  m_cnt   = 0;
   logic m_valid = 1'b0;

   always #5 clk = ~clk;

   sumu2_voter #(.THRESHOLD(4)) dut4 (
      .clk(clk), .rst(rst),
      .A1(ballots[0]), .A2(ballots[1]), .A3(ballots[2]), .A4(ballots[3]),
      .A5(ballots[4]), .A6(ballots[5]), .A7(ballots[6]),
      .OUT(out4), .COUNT(count4)
   );

   sumu2_voter #(.THRESHOLD(7)) dut7 (
      .clk(clk), .rst(rst),
      .A1(ballots[0]), .A2(ballots[1]), .A3(ballots[2]), .A4(ballots[3]),
      .A5(ballots[4]), .A6(ballots[5]), .A7(ballots[6]),
      .OUT(out7), .COUNT(count7)
   );

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
   endtask

   // Model: tally is the number of yes ballots seen at the last edge, cleared by reset.
   always @(posedge clk) begin
      if (rst) begin
         m_cnt   <= 0;
         m_valid <= 1'b1;
      end else begin
         m_cnt <= $countones(ballots);
      end
   end

   always @(negedge clk) begin
      if (m_valid) begin
         check("model_count4", int'(count4), m_cnt);
         check("model_out4",   int'(out4),   int'(m_cnt >= 4));
         check("model_count7", int'(count7), m_cnt);
         check("model_out7",   int'(out7),   int'(m_cnt >= 7));
      end
   end

   task automatic step(input logic r, input logic [6:0] b);
      rst     = r;
      ballots = b;
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      rst     = 1'b1;
      ballots = 7'h7f;
      @(negedge clk);

      for (int i = 0; i < 2; i++) begin
         step(1'b1, 7'b1111111);
         check("reset_count", int'(count4), 0);
         check("reset_out",   int'(out4),   0);
         check("reset_out7",  int'(out7),   0);
      end

      step(1'b0, 7'b1111111);
      check("release_count", int'(count4), 7);
      check("release_out",   int'(out4),   1);
      check("release_out7",  int'(out7),   1);

      step(1'b0, 7'b0000000);
      check("zero_count", int'(count4), 0);
      check("zero_out",   int'(out4),   0);

      step(1'b0, 7'b0000111);
      check("three_count", int'(count4), 3);
      check("three_out",   int'(out4),   0);

      step(1'b0, 7'b0001111);
      check("four_count", int'(count4), 4);
      check("four_out",   int'(out4),   1);

      step(1'b0, 7'b0000111);
      check("drop_a4_count", int'(count4), 3);
      check("drop_a4_out",   int'(out4),   0);

      for (int p = 0; p < 128; p++) begin
         step(1'b0, 7'(p));
         if (p == 7'b1010101) begin
            check("alt_count", int'(count4), 4);
            check("alt_out",   int'(out4),   1);
         end
      end

      step(1'b0, 7'b0111111);
      check("six_count", int'(count4), 6);
      check("six_out",   int'(out4),   1);
      check("six_out7",  int'(out7),   0);

      step(1'b1, 7'b1111111);
      check("midrst_count", int'(count4), 0);
      check("midrst_out",   int'(out4),   0);

      step(1'b0, 7'b1111111);
      check("seven_out7",   int'(out7),   1);
      check("seven_count7", int'(count7), 7);

      #1;
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/sumu2_voter.md
Name: sumu2_voter

Overview:
- Seven-input majority voter ("7-person voting machine").
- Seven single-bit ballots A1..A7 are counted each clock.
- OUT asserts when the number of 1-ballots reaches THRESHOLD (default 4, strict majority of 7).
- Standalone leaf block. It sits behind switch/button conditioning logic and drives a pass/fail indicator. A registered tally output is provided for display.

Parameters:
- THRESHOLD, default 4: minimum number of 1-ballots for OUT=1. Legal range 1..7; values outside this range are a compile-time error.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- A1  input  1  ballot 1 (1 = yes).
- A2  input  1  ballot 2.
- A3  input  1  ballot 3.
- A4  input  1  ballot 4.
- A5  input  1  ballot 5.
- A6  input  1  ballot 6.
- A7  input  1  ballot 7.
- OUT  output  1  vote result: 1 when yes-count >= THRESHOLD.
- COUNT  output  3  number of yes ballots, 0..7 unsigned.

Interface decision: one clock (clk); reset rst is synchronous and active-high.

Behaviour:
- Reset: on a rising edge of clk with rst=1, OUT=0 and COUNT=0. Ballots are ignored on that edge. Reset mid-operation clears immediately on that edge, with no partial state.
- Normal operation: on each rising edge with rst=0, sample A1..A7 and compute the popcount.
  - COUNT <= popcount.
  - OUT <= (popcount >= THRESHOLD).
- Latency: 1 cycle. Outputs reflect the ballots sampled at the most recent edge. There is no combinational path from A* to outputs.
- OUT and COUNT always update on the same edge and are always mutually consistent: OUT == (COUNT >= THRESHOLD).
- Arithmetic:
  - Popcount is a 3-bit unsigned sum of seven 1-bit values; max 7, so no overflow.
  - The comparison is unsigned, against THRESHOLD zero-extended to 3 bits.
- Boundaries, with default THRESHOLD=4:
  - count 3 -> OUT=0.
  - count 4 -> OUT=1.
  - count 0 -> OUT=0, COUNT=0.
  - count 7 -> OUT=1, COUNT=7.
- Inputs are assumed synchronous to clk. No synchronizers or debounce are included; those are upstream responsibility.
- No X-propagation handling is required beyond standard RTL semantics. Outputs are defined from the first reset onward.

Decomposition:
- Shared package sumu2_pkg:
  - constant N_VOTERS = 7.
  - constant COUNT_W = 3.
  - typedef ballot_t as a 7-bit logic vector.
  - typedef count_t as a COUNT_W-bit unsigned.
- One sub-module, popcount7: purely combinational. Input is a 7-bit ballot_t; output is count_t.
- Top level:
  - Packs A1..A7 into ballot_t, with A1 at bit 0.
  - Instantiates popcount7.
  - Holds the COUNT and OUT registers and the threshold comparison.

Test Plan:
- Reset: hold rst=1 for 2 cycles with all A*=1 -> OUT=0, COUNT=0 throughout reset. First edge after release: COUNT=7, OUT=1.
- All zero: rst=0, A1..A7=0000000 -> after 1 edge, COUNT=0, OUT=0.
- Below majority: A1=A2=A3=1, A4..A7=0 -> COUNT=3, OUT=0 one cycle later.
- At threshold: A1..A4=1, A5..A7=0 -> COUNT=4, OUT=1. Then drop A4 -> next edge COUNT=3, OUT=0.
- Position independence and exhaustive check: sweep all 128 ballot patterns, one per cycle. Each cycle requires COUNT = popcount of the previous pattern and OUT = (COUNT >= 4). For example, pattern A7,A5,A3,A1=1 gives COUNT=4, OUT=1.
- Reset mid-operation and parameter check:
  - With COUNT=6, OUT=1, assert rst for one edge -> OUT=0, COUNT=0 on that edge, ballots ignored.
  - Separate instance with THRESHOLD=7: six yes votes -> OUT=0; seven -> OUT=1.
